// File: rtl/slv_rsp_arb.sv
// rtl/slv_rsp_arb.sv - round-robin arbiter funnelling NCH slave channels onto one response channel
// A grant holds the response channel until rsp_ack or a TMO-cycle timeout, then idles one cycle.
module slv_rsp_arb #(
    parameter int NCH = 4,
    parameter int DW  = 32,
    parameter int TMO = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         ch_req,
    input  logic [NCH*DW-1:0]      ch_data,
    output logic [NCH-1:0]         ch_ack,
    output logic                   rsp_req,
    output logic [DW-1:0]          rsp_data,
    input  logic                   rsp_ack,
    output logic                   rsp_err,
    output logic [$clog2(NCH)-1:0] grant_id,
    output logic                   busy
);

    localparam int GW = $clog2(NCH);
    localparam int CW = $clog2(TMO);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
    localparam logic [GW-1:0] LAST_RST = GW'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q,      state_d;
    logic [GW-1:0]   grant_q,      grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [DW-1:0]   rsp_data_q,   rsp_data_d;
    logic            rsp_req_q,    rsp_req_d;
    logic [NCH-1:0]  ch_ack_q,     ch_ack_d;
    logic            rsp_err_q,    rsp_err_d;
    logic [CW-1:0]   cnt_q,        cnt_d;

    logic [GW-1:0]   winner;
    logic [GW-1:0]   cand;
    logic            found;

    // Search starts just above the previous winner so every channel gets a turn.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            cand = GW'((int'(last_grant_q) + k) % NCH);
            if (!found && ch_req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_req_d    = rsp_req_q;
        ch_ack_d     = '0;
        rsp_err_d    = 1'b0;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_GRANT;
                    grant_d    = winner;
                    rsp_data_d = ch_data[winner*DW +: DW];
                    rsp_req_d  = 1'b1;
                    cnt_d      = '0;
                end
            end
            S_GRANT: begin
                // An ack on the final wait cycle still counts as success.
                if (rsp_ack || (cnt_q == CNT_LAST)) begin
                    state_d           = S_DONE;
                    rsp_req_d         = 1'b0;
                    ch_ack_d[grant_q] = 1'b1;
                    rsp_err_d         = ~rsp_ack;
                    last_grant_d      = grant_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            rsp_data_q   <= '0;
            rsp_req_q    <= 1'b0;
            ch_ack_q     <= '0;
            rsp_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_req_q    <= rsp_req_d;
            ch_ack_q     <= ch_ack_d;
            rsp_err_q    <= rsp_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ch_ack   = ch_ack_q;
    assign rsp_req  = rsp_req_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_slv_rsp_arb.sv
// tb/tb_slv_rsp_arb.sv - table-driven bench with an expected-grant scoreboard for slv_rsp_arb
module tb_slv_rsp_arb;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_req;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_ack;
    logic              rsp_req;
    logic [DW-1:0]     rsp_data;
    logic              rsp_ack;
    logic              rsp_err;
    logic [1:0]        grant_id;
    logic              busy;

    slv_rsp_arb #(.NCH(NCH), .DW(DW), .TMO(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_req   (ch_req),
        .ch_data  (ch_data),
        .ch_ack   (ch_ack),
        .rsp_req  (rsp_req),
        .rsp_data (rsp_data),
        .rsp_ack  (rsp_ack),
        .rsp_err  (rsp_err),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  gid;
        logic [31:0] data;
        logic        err;
    } exp_t;

    // ack_at: 0 = rsp_ack raised already in IDLE, n = raised on the n-th rsp_req-high cycle, 99 = never
    typedef struct {
        logic [3:0] req;
        int         ack_at;
        logic [1:0] gid;
        int         len;
        logic       err;
        logic       period;
    } vec_t;

    logic [31:0] chd [NCH];
    exp_t        exp_q [$];
    exp_t        e;
    vec_t        vecs [14];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          last_rise = 0;
    logic        prev_req = 1'b0;
    logic [3:0]  ack_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (rsp_req) begin
                check("exp_pending_on_req", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    check(prev_req ? "grant_id_hold" : "grant_id", grant_id, exp_q[0].gid);
                    check(prev_req ? "rsp_data_hold" : "rsp_data", rsp_data, exp_q[0].data);
                end
            end
            if (ch_ack != '0) begin
                check("exp_pending_on_ack", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    ack_exp = 4'b0001 << e.gid;
                    check("ch_ack", ch_ack, ack_exp);
                    check("rsp_err", rsp_err, e.err);
                end
            end else if (rsp_err) begin
                check("rsp_err_without_ack", rsp_err, 1'b0);
            end
            prev_req = rsp_req;
        end
    end

    task automatic do_vec(input vec_t v);
        int n;
        int len;
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        ch_req  = v.req;
        rsp_ack = (v.ack_at == 0);
        exp_q.push_back('{gid: v.gid, data: chd[v.gid], err: v.err});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_req && n < 5);
        check("grant_latency", n, 1);
        if (v.period) check("grant_period", cyc - last_rise, 3);
        last_rise = cyc;
        len = 0;
        while (rsp_req && len < 40) begin
            len++;
            if (len == v.ack_at) rsp_ack = 1'b1;
            @(negedge clk);
        end
        check("rsp_req_len", len, v.len);
        rsp_ack = 1'b0;
        @(negedge clk);
        check("busy_after_done", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        chd[0] = 32'hA5A5_0001;
        chd[1] = 32'h5A5A_1002;
        chd[2] = 32'h3C3C_2003;
        chd[3] = 32'hC3C3_3004;
        for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = chd[i];

        vecs[0]  = '{4'b1111,  0, 2'd0,  1, 1'b0, 1'b0};
        vecs[1]  = '{4'b1111,  0, 2'd1,  1, 1'b0, 1'b1};
        vecs[2]  = '{4'b1111,  0, 2'd2,  1, 1'b0, 1'b1};
        vecs[3]  = '{4'b1111,  0, 2'd3,  1, 1'b0, 1'b1};
        vecs[4]  = '{4'b1111,  0, 2'd0,  1, 1'b0, 1'b1};
        vecs[5]  = '{4'b0001,  0, 2'd0,  1, 1'b0, 1'b0};
        vecs[6]  = '{4'b0100, 99, 2'd2, 16, 1'b1, 1'b0};
        vecs[7]  = '{4'b0100, 16, 2'd2, 16, 1'b0, 1'b0};
        vecs[8]  = '{4'b0100, 15, 2'd2, 15, 1'b0, 1'b0};
        vecs[9]  = '{4'b1010,  2, 2'd3,  2, 1'b0, 1'b0};
        vecs[10] = '{4'b1010,  1, 2'd1,  1, 1'b0, 1'b0};
        vecs[11] = '{4'b1001,  3, 2'd3,  3, 1'b0, 1'b0};
        vecs[12] = '{4'b1001,  0, 2'd0,  1, 1'b0, 1'b0};
        vecs[13] = '{4'b0110,  5, 2'd1,  5, 1'b0, 1'b0};

        rst     = 1'b1;
        ch_req  = '0;
        rsp_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_req",  rsp_req,  1'b0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_ch_ack",   ch_ack,   4'h0);
        check("rst_rsp_err",  rsp_err,  1'b0);
        check("rst_grant_id", grant_id, 2'd0);
        check("rst_busy",     busy,     1'b0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) do_vec(vecs[i]);

        // rsp_ack pulse with nothing requested must leave everything untouched
        ch_req  = '0;
        rsp_ack = 1'b1;
        @(negedge clk);
        rsp_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("idle_ack_busy",     busy,     1'b0);
            check("idle_ack_rsp_req",  rsp_req,  1'b0);
            check("idle_ack_ch_ack",   ch_ack,   4'h0);
            check("idle_ack_grant_id", grant_id, 2'd1);
            check("idle_ack_rsp_data", rsp_data, chd[1]);
        end

        // reset in the middle of a ch2 grant, then ch1 must win first
        ch_req = 4'b0100;
        exp_q.push_back('{gid: 2'd2, data: chd[2], err: 1'b0});
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rsp_req && n < 5);
            check("mid_rst_grant_seen", rsp_req, 1'b1);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp_req",  rsp_req,  1'b0);
        check("mid_rst_ch_ack",   ch_ack,   4'h0);
        check("mid_rst_rsp_err",  rsp_err,  1'b0);
        check("mid_rst_busy",     busy,     1'b0);
        check("mid_rst_grant_id", grant_id, 2'd0);
        void'(exp_q.pop_front());
        rst = 1'b0;
        do_vec('{4'b0110, 0, 2'd1, 1, 1'b0, 1'b0});

        ch_req = '0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slv_rsp_arb.md
SLV_RSP_ARB -- requirements
Module: slv_rsp_arb

Interface
REQ-001 Parameter NCH, default 4, number of requesting slave channels (2..8).
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter TMO, default 16, max cycles to wait for rsp_ack before abort (≥2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ch_req  input  NCH  per-channel request; held high with data stable until that channel's ack.
REQ-007 ch_data  input  NCH*DW  per-channel data, channel i at bits [i*DW +: DW].
REQ-008 ch_ack  output  NCH  per-channel one-cycle completion pulse.
REQ-009 rsp_req  output  1  shared response channel request.
REQ-010 rsp_data  output  DW  shared response data, registered.
REQ-011 rsp_ack  input  1  shared channel acknowledge.
REQ-012 rsp_err  output  1  one-cycle pulse on timeout abort.
REQ-013 grant_id  output  $clog2(NCH)  index of channel currently granted.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, GRANT and DONE.
REQ-016 In IDLE with any ch_req bit high, the block SHALL pick the winner round-robin, searching upward from last_grant+1 and wrapping at NCH-1 to 0.
REQ-017 On the IDLE->GRANT edge, the block SHALL register grant_id=winner and rsp_data=winner's ch_data and set rsp_req=1, so rsp_req rises one cycle after ch_req is sampled.
REQ-018 In GRANT, rsp_req, rsp_data and grant_id SHALL hold stable until exit.
REQ-019 In GRANT with rsp_ack=1 sampled, the next cycle SHALL have rsp_req=0, ch_ack[grant_id]=1 for exactly one cycle, last_grant=grant_id, and the FSM in DONE.
REQ-020 A wait counter SHALL clear on GRANT entry and increment each GRANT cycle without rsp_ack.
REQ-021 When the counter reaches TMO-1 without rsp_ack, the next cycle SHALL have rsp_req=0, ch_ack[grant_id]=1, rsp_err=1 (both one cycle), last_grant=grant_id, and the FSM in DONE.
REQ-022 When rsp_ack arrives on the same cycle the counter reaches TMO-1, the block SHALL treat it as success with rsp_err=0.
REQ-023 DONE SHALL last exactly one cycle, ignore ch_req, then go to IDLE, so a requester can drop its req before re-arbitration.
REQ-024 rsp_ack sampled in IDLE or DONE SHALL be ignored.
REQ-025 A granted channel dropping ch_req during GRANT SHALL NOT abort the transfer.
REQ-026 Minimum transfer period SHALL be 3 cycles per grant (IDLE, GRANT, DONE) with a zero-wait rsp_ack.
REQ-027 At most one ch_ack bit SHALL be high in any cycle.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE with rsp_req=0, rsp_data=0, ch_ack=0, rsp_err=0, grant_id=0, busy=0, wait counter=0 and last_grant=NCH-1, so channel 0 has first priority.
REQ-029 rst asserted mid-GRANT SHALL drop rsp_req the next cycle with no ch_ack and no rsp_err pulse.
REQ-030 Reset SHALL take priority over all other inputs.

Verification
REQ-031 After reset, ch_req=4'b0001 with ch0 data 0xA5A5_0001 and rsp_ack held high -> rsp_req high 1 cycle later with rsp_data=0xA5A5_0001 and grant_id=0, then ch_ack=4'b0001 1 cycle after that, then busy low after DONE.
REQ-032 ch_req=4'b1111 held continuously with zero-wait rsp_ack -> grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-033 ch_req=4'b0100 with rsp_ack never asserted and TMO=16 -> rsp_req high for 16 cycles, then rsp_err=1 and ch_ack=4'b0100 on the same cycle, then IDLE.
REQ-034 rsp_ack asserted on the 16th GRANT cycle (TMO=16) -> ch_ack pulse with rsp_err=0.
REQ-035 rst pulsed during GRANT for ch2 -> rsp_req=0 and ch_ack=0 next cycle; with ch_req=4'b0110 afterwards, ch1 is granted first.
REQ-036 rsp_ack pulsed in IDLE with no ch_req -> no outputs change and busy stays 0.
